// File: rtl/uart_tx_buf_if.sv
// rtl/uart_tx_buf_if.sv - byte write strobe and serializer req/ack bundle for uart_tx_buf
//
// Signals:
//   wr_en    host write strobe, one byte per cycle
//   wr_data  byte to enqueue
//   tx_req   frame request to the serializer, held until tx_ack
//   tx_data  frame byte, stable while tx_req is high
//   tx_ack   serializer one-cycle end-of-frame pulse
// Modports:
//   slave    the buffer side (uart_tx_buf)
//   master   the environment side (host writer plus serializer)

interface uart_tx_buf_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ack;

    modport slave (
        input  wr_en,
        input  wr_data,
        input  tx_ack,
        output tx_req,
        output tx_data
    );

    modport master (
        output wr_en,
        output wr_data,
        output tx_ack,
        input  tx_req,
        input  tx_data
    );
endinterface

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - transmit FIFO and frame sequencer feeding a UART serializer
//
// Ports:
//   i_clk         clock
//   i_reset_n     asynchronous active-low reset
//   i_flush       synchronous FIFO clear (an active frame is not aborted)
//   i_tx_enable   permit starting new frames
//   i_gap         extra idle cycles inserted after each frame
//   i_ovf_clr     clear the sticky overflow flag
//   o_full        FIFO holds 2**DEPTH_LOG2 entries
//   o_empty       FIFO holds no entries
//   o_level       current entry count
//   o_ovf         sticky: a write was dropped because the FIFO was full
//   o_busy        sequencer is not idle
//   bus           write strobe/data in, serializer req/data/ack (slave modport)

module uart_tx_buf #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic                  i_tx_enable,
    input  logic [15:0]           i_gap,
    input  logic                  i_ovf_clr,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_ovf,
    output logic                  o_busy,
    uart_tx_buf_if.slave          bus
);

    localparam int                 DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_ovf;
    logic                    r_tx_req;
    logic [DATA_W-1:0]       r_tx_data;
    logic [15:0]             r_gap_cnt;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_wr_acc;
    logic                    w_ovf_set;

    // Status decodes come only from the count register, so the write strobe
    // never reaches the flags combinationally.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A pop needs a registered non-empty FIFO, so a write into an empty FIFO
    // can never pair with a pop. A flush cycle suppresses the pop so the
    // sequencer never starts a frame from an entry being discarded.
    assign w_pop = (r_state == ST_IDLE) && i_tx_enable && !w_empty && !i_flush;

    // When full, a same-cycle pop frees the slot the write lands in.
    assign w_wr_acc  = bus.wr_en && !i_flush && (!w_full || w_pop);
    assign w_ovf_set = bus.wr_en && !i_flush && w_full && !w_pop;

    // FIFO bookkeeping: pointers wrap naturally at DEPTH_LOG2 bits.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_wr_acc, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            // A new drop in the same cycle as a clear keeps the flag set.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage array has no reset; its contents are only meaningful behind
    // the pointers, which are reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Frame sequencer. tx_data is captured at pop time and frozen through
    // SEND, so a flush or later writes cannot disturb the frame on the wire.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_req <= 1'b0;
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_tx_req  <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ack) begin
                        r_tx_req  <= 1'b0;
                        r_gap_cnt <= i_gap;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // GAP lasts i_gap+1 cycles, IDLE then adds one more, so
                    // req stays low for at least two cycles between frames.
                    r_tx_req <= 1'b0;
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tx_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_level     = r_count;
    assign o_ovf       = r_ovf;
    assign o_busy      = (r_state != ST_IDLE);
    assign bus.tx_req  = r_tx_req;
    assign bus.tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - scoreboard bench for uart_tx_buf

module tb_uart_tx_buf;

    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 4;

    logic                i_clk       = 1'b0;
    logic                i_reset_n   = 1'b0;
    logic                i_flush     = 1'b0;
    logic                i_tx_enable = 1'b0;
    logic [15:0]         i_gap       = 16'd0;
    logic                i_ovf_clr   = 1'b0;
    logic                o_full;
    logic                o_empty;
    logic [DEPTH_LOG2:0] o_level;
    logic                o_ovf;
    logic                o_busy;

    uart_tx_buf_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_buf #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_flush),
        .i_tx_enable (i_tx_enable),
        .i_gap       (i_gap),
        .i_ovf_clr   (i_ovf_clr),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_level     (o_level),
        .o_ovf       (o_ovf),
        .o_busy      (o_busy),
        .bus         (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame monitor: each rising req takes the next expected byte, and the
    // byte must not change for as long as req stays high.
    initial begin : monitor
        logic       prev_req;
        logic [7:0] held;
        prev_req = 1'b0;
        held     = 8'h00;
        forever begin
            @(posedge i_clk);
            #2;
            if (bus.tx_req && !prev_req) begin
                check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("frame_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
                held = bus.tx_data;
            end else if (bus.tx_req && prev_req) begin
                check("frame_data_stable", 32'(bus.tx_data), 32'(held));
            end
            prev_req = bus.tx_req;
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic write(input logic [7:0] d, input bit accepted);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (accepted) exp_q.push_back(d);
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int t = 0;
        while (!bus.tx_req && t < 100) begin
            step();
            t++;
        end
        check(name, 32'(bus.tx_req), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (o_busy && t < 200) begin
            step();
            t++;
        end
        check(name, 32'(o_busy), 32'd0);
    endtask

    task automatic ack();
        bus.tx_ack = 1'b1;
        step();
        bus.tx_ack = 1'b0;
    endtask

    task automatic drain(input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            wait_req("drain_req");
            step(hold);
            ack();
        end
        wait_idle("drain_idle");
    endtask

    initial begin : stimulus
        int  low;
        bit  seen;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_ack  = 1'b0;

        // Reset values
        step(2);
        check("rst_req",   32'(bus.tx_req),  32'd0);
        check("rst_data",  32'(bus.tx_data), 32'h00);
        check("rst_empty", 32'(o_empty),     32'd1);
        check("rst_full",  32'(o_full),      32'd0);
        check("rst_level", 32'(o_level),     32'd0);
        check("rst_ovf",   32'(o_ovf),       32'd0);
        check("rst_busy",  32'(o_busy),      32'd0);
        i_reset_n = 1'b1;
        step();

        // Single byte, gap 2
        i_gap       = 16'd2;
        i_tx_enable = 1'b1;
        write(8'hA5, 1'b1);
        check("single_level_after_write", 32'(o_level), 32'd1);
        check("single_empty_after_write", 32'(o_empty), 32'd0);
        check("single_req_not_yet",       32'(bus.tx_req), 32'd0);
        step();
        check("single_req_rise",   32'(bus.tx_req),  32'd1);
        check("single_data",       32'(bus.tx_data), 32'hA5);
        check("single_empty_pop",  32'(o_empty),     32'd1);
        step(19);
        ack();
        check("single_req_after_ack",  32'(bus.tx_req), 32'd0);
        check("single_busy_after_ack", 32'(o_busy),     32'd1);
        step(2);
        check("single_busy_in_gap",    32'(o_busy),     32'd1);
        step();
        check("single_busy_done",      32'(o_busy),     32'd0);
        check("single_empty_done",     32'(o_empty),    32'd1);

        // Burst of 16 with gap 3
        i_tx_enable = 1'b0;
        i_gap       = 16'd3;
        for (int i = 1; i <= 16; i++) write(8'(i), 1'b1);
        check("burst_full",  32'(o_full),     32'd1);
        check("burst_level", 32'(o_level),    32'd16);
        check("burst_noreq", 32'(bus.tx_req), 32'd0);
        i_tx_enable = 1'b1;
        for (int f = 0; f < 16; f++) begin
            wait_req("burst_req");
            step(2);
            ack();
            check("burst_req_drop", 32'(bus.tx_req), 32'd0);
            if (f < 15) begin
                low = 1;
                step();
                while (!bus.tx_req && low < 50) begin
                    low++;
                    step();
                end
                check("burst_gap_low_cycles", 32'(low), 32'd5);
            end
        end
        wait_idle("burst_idle");
        check("burst_empty", 32'(o_empty), 32'd1);

        // Overflow
        i_tx_enable = 1'b0;
        i_gap       = 16'd0;
        for (int i = 0; i < 16; i++) write(8'h20 + 8'(i), 1'b1);
        write(8'hFF, 1'b0);
        check("ovf_level", 32'(o_level), 32'd16);
        check("ovf_set",   32'(o_ovf),   32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hFE;
        i_ovf_clr   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
        i_ovf_clr   = 1'b0;
        check("ovf_set_beats_clr", 32'(o_ovf),   32'd1);
        check("ovf_level_hold",    32'(o_level), 32'd16);
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
        check("ovf_clear", 32'(o_ovf), 32'd0);

        // Full FIFO, enable rises with a write: write accepted via the pop
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;
        exp_q.push_back(8'h77);
        i_tx_enable = 1'b1;
        step();
        bus.wr_en   = 1'b0;
        check("fullpop_level", 32'(o_level),    32'd16);
        check("fullpop_full",  32'(o_full),     32'd1);
        check("fullpop_ovf",   32'(o_ovf),      32'd0);
        check("fullpop_req",   32'(bus.tx_req), 32'd1);
        drain(17, 1);
        check("fullpop_empty", 32'(o_empty), 32'd1);

        // Flush while a frame is in SEND
        i_tx_enable = 1'b0;
        for (int i = 0; i < 4; i++) write(8'h31 + 8'(i), 1'b1);
        i_tx_enable = 1'b1;
        step();
        check("flush_req_active", 32'(bus.tx_req),  32'd1);
        i_flush     = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        step();
        i_flush     = 1'b0;
        bus.wr_en   = 1'b0;
        exp_q.delete();
        check("flush_level", 32'(o_level),     32'd0);
        check("flush_empty", 32'(o_empty),     32'd1);
        check("flush_ovf",   32'(o_ovf),       32'd0);
        check("flush_req",   32'(bus.tx_req),  32'd1);
        check("flush_data",  32'(bus.tx_data), 32'h31);
        step(3);
        check("flush_data_held", 32'(bus.tx_data), 32'h31);
        ack();
        check("flush_req_drop", 32'(bus.tx_req), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tx_req) seen = 1'b1;
        end
        check("flush_no_more_req", 32'(seen),   32'd0);
        check("flush_idle",        32'(o_busy), 32'd0);

        // Asynchronous reset in the middle of a frame
        i_tx_enable = 1'b0;
        write(8'h55, 1'b1);
        write(8'h66, 1'b1);
        i_tx_enable = 1'b1;
        step();
        check("arst_req_before", 32'(bus.tx_req), 32'd1);
        step(2);
        #3;
        i_reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_req",   32'(bus.tx_req),  32'd0);
        check("arst_data",  32'(bus.tx_data), 32'h00);
        check("arst_level", 32'(o_level),     32'd0);
        check("arst_empty", 32'(o_empty),     32'd1);
        check("arst_full",  32'(o_full),      32'd0);
        check("arst_ovf",   32'(o_ovf),       32'd0);
        check("arst_busy",  32'(o_busy),      32'd0);
        step(2);
        i_reset_n = 1'b1;
        step();
        ack();
        check("arst_spurious_ack_req",  32'(bus.tx_req), 32'd0);
        check("arst_spurious_ack_busy", 32'(o_busy),     32'd0);
        step(5);
        check("arst_still_idle", 32'(bus.tx_req), 32'd0);

        // Normal operation resumes after reset
        write(8'h5A, 1'b1);
        wait_req("post_rst_req");
        check("post_rst_data", 32'(bus.tx_data), 32'h5A);
        step(2);
        ack();
        wait_idle("post_rst_idle");

        step(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
